rv32i_hazard_scoreboard: RTL and testbench
==========================================

Name: rv32i_hazard_scoreboard

Overview:
Parametrised hazard and forwarding unit for the RV32i pipelined core. It replaces fixed EXEC/MEM/WB stall-only dependency detection with a scoreboard of NB_STAGES in-flight destination entries. It produces per-operand forwarding selects, load-use stalls, a pending-register bitmap and a stall performance counter. It sits beside the control path in the DEC stage; the datapath uses fwd_rs*_sel_o to steer its operand muxes.

Parameters:
NB_REGS, 32, number of architectural registers; REG_ADDR_W = $clog2(NB_REGS) (derived, localparam)
NB_STAGES, 3, stages after DEC that can hold a pending write; index 0 = EXEC, NB_STAGES-1 = WB
FORWARD_EN, 1, 1 = forward from any stage; 0 = stall-only mode (stall until no matching entry remains)
LOAD_STAGE, 1, first stage index at which load data is forwardable; must be < NB_STAGES
CNT_W, 16, width of the stall counter
SEL_W, $clog2(NB_STAGES+1), width of the forwarding selects (derived, localparam)

Ports:
clk_i  in  1  clock, rising edge
resetn_i  in  1  reset, synchronous, active-low
dec_valid_i  in  1  DEC holds a real instruction
dec_rs1_i  in  REG_ADDR_W  rs1 address in DEC
dec_rs1_re_i  in  1  DEC instruction reads rs1
dec_rs2_i  in  REG_ADDR_W  rs2 address in DEC
dec_rs2_re_i  in  1  DEC instruction reads rs2
dec_rd_i  in  REG_ADDR_W  rd address in DEC
dec_rd_we_i  in  1  DEC instruction writes rd
dec_is_load_i  in  1  DEC instruction is a load
flush_i  in  1  branch taken in EXEC; kill DEC and EXEC
hold_i  in  1  external freeze (e.g. memory wait)
stall_o  out  1  hold PC/DEC and insert a bubble into EXEC
fwd_rs1_sel_o  out  SEL_W  0 = register file; k = forward from stage k-1
fwd_rs2_sel_o  out  SEL_W  same encoding, for rs2
pending_o  out  NB_REGS  bit r = 1 when a valid entry will write register r
stall_count_o  out  CNT_W  saturating count of stall cycles

Behaviour:
- State: entry[0..NB_STAGES-1] = {valid, rd, we, is_load}. The entries and the counter are the only registers.
- Reset (synchronous, resetn_i=0 at an edge): all entries invalid, counter = 0. Consequently stall_o=0, fwd sels=0, pending_o=0.
- Reset asserted mid-operation discards all in-flight entries at that edge; there is no drain.
- Entry write-enable: dec_rd_we_i && dec_rd_i != 0. Register x0 is never pending, never matched and never forwarded.
- Match on operand s at stage k: entry[k].valid && entry[k].we && entry[k].rd == rs_s && rs_s_re && rs_s != 0.
- FORWARD_EN=0: hazard_s = any k matches; fwd_rs_s_sel = 0 always.
- FORWARD_EN=1: k* = the youngest (smallest k) matching stage.
  - If entry[k*].is_load && k* < LOAD_STAGE: hazard_s = 1.
  - Otherwise hazard_s = 0 and fwd_rs_s_sel = k*+1.
  - With no match, fwd_rs_s_sel = 0.
- stall_o = (hazard_1 || hazard_2) && dec_valid_i && !flush_i. This is combinational, with zero-cycle latency.
- fwd sels are forced to 0 whenever stall_o=1 or dec_valid_i=0.
- Advance, on an edge with hold_i=0:
  - entry[k] <= entry[k-1] for k ≥ 1.
  - entry[0] <= bubble if (stall_o || flush_i || !dec_valid_i); otherwise DEC fields.
- Edge with hold_i=1: all entries are frozen, except that flush_i=1 still clears entry[0].valid. Flush has priority over hold for EXEC.
- flush_i and stall_o cannot both be asserted, because flush_i masks stall_o.
- pending_o: combinational OR of onehot(entry[k].rd) over valid, we entries; bit 0 is always 0.
- stall_count_o: increments on an edge when stall_o && !hold_i; saturates at 2^CNT_W-1 and never wraps.

Decomposition:
- RV32i_pkg additions:
  - localparam FWD_SEL_RF = 0
  - typedef struct packed sb_entry_t {valid, rd[4:0], we, is_load}
  - localparam NOP_INSTR = 32'h00000013, shared with the control path
- One sub-module, rv32i_hazard_match: per-operand priority comparator over all entries, outputting {hazard, sel}. It is instantiated twice, once for rs1 and once for rs2.

Test Plan:
1. FORWARD_EN=1: `addi x5,x0,1` then `add x6,x5,x5` -> stall_o=0, fwd_rs1_sel_o=1, fwd_rs2_sel_o=1; the next cycle shows sel=2 for a dependent instruction issued one slot later.
2. `lw x7` then `add x8,x7,x0` (LOAD_STAGE=1) -> stall_o=1 for exactly 1 cycle, then fwd_rs1_sel_o=2; stall_count_o=1.
3. FORWARD_EN=0, same pair as scenario 1 -> stall_o=1 for 3 cycles, then sel=0; stall_count_o=3.
4. `addi x0,x0,5` then `add x9,x0,x0` -> no stall, sels=0, pending_o=0 throughout.
5. Load-use hazard with flush_i=1 in the same cycle -> stall_o=0; the next cycle entry[0] is a bubble and pending_o lacks the DEC rd bit.
6. Pending x5 in stage 1, hold_i=1 for 4 cycles with a dependent load-use stall -> pending_o unchanged and stall_count_o frozen; resetn_i=0 for one edge -> pending_o=0 and stall_count_o=0.

Source files
------------

// File: rtl/rv32i_hazard_scoreboard_pkg.sv
// Shared scoreboard types and constants for the RV32i hazard/forwarding unit.
// Pure declarations: no logic, no latency, no backpressure.
package rv32i_hazard_scoreboard_pkg;

    localparam int          FWD_SEL_RF = 0;
    localparam logic [31:0] NOP_INSTR  = 32'h00000013;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       is_load;
    } sb_entry_t;

endpackage

// File: rtl/rv32i_hazard_match.sv
// Priority comparator of one source operand against every in-flight scoreboard entry.
// Purely combinational; stage 0 (youngest) wins when several stages match.
module rv32i_hazard_match #(
    parameter int NB_STAGES  = 3,
    parameter int REG_ADDR_W = 5,
    parameter bit FORWARD_EN = 1'b1,
    parameter int LOAD_STAGE = 1,
    parameter int SEL_W      = 2
) (
    input  logic [REG_ADDR_W-1:0]           rs,
    input  logic                            rs_re,
    input  logic [NB_STAGES-1:0]            ent_valid,
    input  logic [NB_STAGES-1:0]            ent_we,
    input  logic [NB_STAGES-1:0]            ent_load,
    input  logic [NB_STAGES*REG_ADDR_W-1:0] ent_rd,
    output logic                            hazard,
    output logic [SEL_W-1:0]                sel
);

    logic found;
    logic hit;

    always_comb begin
        hazard = 1'b0;
        sel    = '0;
        found  = 1'b0;
        hit    = 1'b0;
        for (int k = 0; k < NB_STAGES; k++) begin
            hit = ent_valid[k] && ent_we[k] && rs_re && (rs != '0) &&
                  (ent_rd[k*REG_ADDR_W +: REG_ADDR_W] == rs);
            if (!FORWARD_EN) begin
                if (hit) hazard = 1'b1;
            end else if (hit && !found) begin
                found = 1'b1;
                // Load data only exists from LOAD_STAGE onward; younger loads must stall.
                if (ent_load[k] && (k < LOAD_STAGE)) hazard = 1'b1;
                else                                 sel    = SEL_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/rv32i_hazard_scoreboard.sv
// Scoreboard of in-flight destinations: forwarding selects, load-use stall, pending bitmap, stall counter.
// Outputs are combinational from DEC inputs and registered entries; hold_i freezes the pipe except flush of EXEC.
module rv32i_hazard_scoreboard
    import rv32i_hazard_scoreboard_pkg::*;
#(
    parameter int  NB_REGS    = 32,
    parameter int  NB_STAGES  = 3,
    parameter bit  FORWARD_EN = 1'b1,
    parameter int  LOAD_STAGE = 1,
    parameter int  CNT_W      = 16,
    localparam int REG_ADDR_W = $clog2(NB_REGS),
    localparam int SEL_W      = $clog2(NB_STAGES + 1)
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  dec_valid_i,
    input  logic [REG_ADDR_W-1:0] dec_rs1_i,
    input  logic                  dec_rs1_re_i,
    input  logic [REG_ADDR_W-1:0] dec_rs2_i,
    input  logic                  dec_rs2_re_i,
    input  logic [REG_ADDR_W-1:0] dec_rd_i,
    input  logic                  dec_rd_we_i,
    input  logic                  dec_is_load_i,
    input  logic                  flush_i,
    input  logic                  hold_i,
    output logic                  stall_o,
    output logic [SEL_W-1:0]      fwd_rs1_sel_o,
    output logic [SEL_W-1:0]      fwd_rs2_sel_o,
    output logic [NB_REGS-1:0]    pending_o,
    output logic [CNT_W-1:0]      stall_count_o
);

    sb_entry_t                     ent_q [NB_STAGES];
    sb_entry_t                     dec_ent;
    logic [CNT_W-1:0]              cnt_q;
    logic [NB_STAGES-1:0]          ent_valid, ent_we, ent_load;
    logic [NB_STAGES*REG_ADDR_W-1:0] ent_rd;
    logic                          hazard1, hazard2;
    logic [SEL_W-1:0]              sel1, sel2;

    always_comb begin
        ent_valid = '0;
        ent_we    = '0;
        ent_load  = '0;
        ent_rd    = '0;
        pending_o = '0;
        for (int k = 0; k < NB_STAGES; k++) begin
            ent_valid[k] = ent_q[k].valid;
            ent_we[k]    = ent_q[k].we;
            ent_load[k]  = ent_q[k].is_load;
            ent_rd[k*REG_ADDR_W +: REG_ADDR_W] = ent_q[k].rd;
            if (ent_q[k].valid && ent_q[k].we) pending_o[ent_q[k].rd] = 1'b1;
        end
        pending_o[0] = 1'b0;
    end

    rv32i_hazard_match #(
        .NB_STAGES (NB_STAGES), .REG_ADDR_W(REG_ADDR_W), .FORWARD_EN(FORWARD_EN),
        .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)
    ) u_match_rs1 (
        .rs(dec_rs1_i), .rs_re(dec_rs1_re_i), .ent_valid(ent_valid), .ent_we(ent_we),
        .ent_load(ent_load), .ent_rd(ent_rd), .hazard(hazard1), .sel(sel1)
    );

    rv32i_hazard_match #(
        .NB_STAGES (NB_STAGES), .REG_ADDR_W(REG_ADDR_W), .FORWARD_EN(FORWARD_EN),
        .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)
    ) u_match_rs2 (
        .rs(dec_rs2_i), .rs_re(dec_rs2_re_i), .ent_valid(ent_valid), .ent_we(ent_we),
        .ent_load(ent_load), .ent_rd(ent_rd), .hazard(hazard2), .sel(sel2)
    );

    always_comb begin
        stall_o       = (hazard1 || hazard2) && dec_valid_i && !flush_i;
        fwd_rs1_sel_o = (stall_o || !dec_valid_i) ? SEL_W'(FWD_SEL_RF) : sel1;
        fwd_rs2_sel_o = (stall_o || !dec_valid_i) ? SEL_W'(FWD_SEL_RF) : sel2;
        stall_count_o = cnt_q;

        dec_ent         = '0;
        dec_ent.valid   = 1'b1;
        dec_ent.rd      = dec_rd_i;
        dec_ent.we      = dec_rd_we_i && (dec_rd_i != '0);
        dec_ent.is_load = dec_is_load_i;
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            for (int k = 0; k < NB_STAGES; k++) ent_q[k] <= '0;
            cnt_q <= '0;
        end else begin
            if (!hold_i) begin
                for (int k = 1; k < NB_STAGES; k++) ent_q[k] <= ent_q[k-1];
                ent_q[0] <= (stall_o || flush_i || !dec_valid_i) ? '0 : dec_ent;
            end else if (flush_i) begin
                ent_q[0].valid <= 1'b0;
            end
            if (stall_o && !hold_i && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_rv32i_hazard_scoreboard.sv
// Directed bench: a forwarding instance and a stall-only instance share the same stimulus.
module tb_rv32i_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        resetn;
    logic        dec_valid;
    logic [4:0]  rs1, rs2, rd;
    logic        rs1_re, rs2_re, rd_we, is_load;
    logic        flush, hold;

    logic        stall, nf_stall;
    logic [1:0]  sel1, sel2, nf_sel1, nf_sel2;
    logic [31:0] pending, nf_pending;
    logic [15:0] cnt, nf_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rv32i_hazard_scoreboard #(.FORWARD_EN(1'b1)) dut (
        .clk_i(clk), .resetn_i(resetn), .dec_valid_i(dec_valid),
        .dec_rs1_i(rs1), .dec_rs1_re_i(rs1_re), .dec_rs2_i(rs2), .dec_rs2_re_i(rs2_re),
        .dec_rd_i(rd), .dec_rd_we_i(rd_we), .dec_is_load_i(is_load),
        .flush_i(flush), .hold_i(hold), .stall_o(stall),
        .fwd_rs1_sel_o(sel1), .fwd_rs2_sel_o(sel2), .pending_o(pending), .stall_count_o(cnt)
    );

    rv32i_hazard_scoreboard #(.FORWARD_EN(1'b0)) dut_nf (
        .clk_i(clk), .resetn_i(resetn), .dec_valid_i(dec_valid),
        .dec_rs1_i(rs1), .dec_rs1_re_i(rs1_re), .dec_rs2_i(rs2), .dec_rs2_re_i(rs2_re),
        .dec_rd_i(rd), .dec_rd_we_i(rd_we), .dec_is_load_i(is_load),
        .flush_i(flush), .hold_i(hold), .stall_o(nf_stall),
        .fwd_rs1_sel_o(nf_sel1), .fwd_rs2_sel_o(nf_sel2), .pending_o(nf_pending), .stall_count_o(nf_cnt)
    );

    task automatic set_dec(input logic v, input logic [4:0] a1, input logic e1,
                           input logic [4:0] a2, input logic e2,
                           input logic [4:0] d, input logic we, input logic ld);
        dec_valid = v; rs1 = a1; rs1_re = e1; rs2 = a2; rs2_re = e2;
        rd = d; rd_we = we; is_load = ld;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        flush = 1'b0; hold = 1'b0;
        set_dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        // A would-be dependent instruction in DEC sees no entries after reset.
        set_dec(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall); end
        checks++; if ({sel1, sel2} !== 4'b0) begin failures++; $display("FAIL reset_sels got=%0d/%0d exp=0/0", sel1, sel2); end
        checks++; if (pending !== 32'h0) begin failures++; $display("FAIL reset_pending got=%h exp=0", pending); end
        checks++; if (cnt !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", cnt); end
    endtask

    task automatic test_forward_alu();
        do_reset();
        set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);   // addi x5,x0,1
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL fwd_addi_stall got=%0b exp=0", stall); end
        tick();
        set_dec(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);   // add x6,x5,x5
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL fwd_add_stall got=%0b exp=0", stall); end
        checks++; if (sel1 !== 2'd1) begin failures++; $display("FAIL fwd_add_sel1 got=%0d exp=1", sel1); end
        checks++; if (sel2 !== 2'd1) begin failures++; $display("FAIL fwd_add_sel2 got=%0d exp=1", sel2); end
        tick();
        set_dec(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd10, 1'b1, 1'b0);  // add x10,x5,x6
        checks++; if (sel1 !== 2'd2) begin failures++; $display("FAIL fwd_later_sel1 got=%0d exp=2", sel1); end
        checks++; if (sel2 !== 2'd1) begin failures++; $display("FAIL fwd_later_sel2 got=%0d exp=1", sel2); end
        checks++; if (pending !== 32'h0000_0060) begin failures++; $display("FAIL fwd_pending got=%h exp=00000060", pending); end
        set_dec(1'b0, 5'd5, 1'b1, 5'd6, 1'b1, 5'd10, 1'b1, 1'b0);
        checks++; if ({sel1, sel2} !== 4'b0) begin failures++; $display("FAIL fwd_invalid_sels got=%0d/%0d exp=0/0", sel1, sel2); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);   // lw x7
        tick();
        set_dec(1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);   // add x8,x7,x0
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%0b exp=1", stall); end
        checks++; if (sel1 !== 2'd0) begin failures++; $display("FAIL lu_sel_during_stall got=%0d exp=0", sel1); end
        tick();
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_stall_after got=%0b exp=0", stall); end
        checks++; if (sel1 !== 2'd2) begin failures++; $display("FAIL lu_sel1 got=%0d exp=2", sel1); end
        checks++; if (sel2 !== 2'd0) begin failures++; $display("FAIL lu_sel2 got=%0d exp=0", sel2); end
        checks++; if (cnt !== 16'd1) begin failures++; $display("FAIL lu_count got=%0d exp=1", cnt); end
    endtask

    task automatic test_stall_only();
        do_reset();
        set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);   // addi x5,x0,1
        tick();
        set_dec(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);   // add x6,x5,x5
        for (int c = 0; c < 3; c++) begin
            checks++; if (nf_stall !== 1'b1) begin failures++; $display("FAIL nf_stall cycle=%0d got=%0b exp=1", c, nf_stall); end
            tick();
        end
        checks++; if (nf_stall !== 1'b0) begin failures++; $display("FAIL nf_release got=%0b exp=0", nf_stall); end
        checks++; if ({nf_sel1, nf_sel2} !== 4'b0) begin failures++; $display("FAIL nf_sels got=%0d/%0d exp=0/0", nf_sel1, nf_sel2); end
        checks++; if (nf_cnt !== 16'd3) begin failures++; $display("FAIL nf_count got=%0d exp=3", nf_cnt); end
    endtask

    task automatic test_x0();
        do_reset();
        set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);   // addi x0,x0,5
        tick();
        set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);   // add x9,x0,x0
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL x0_stall got=%0b exp=0", stall); end
        checks++; if ({sel1, sel2} !== 4'b0) begin failures++; $display("FAIL x0_sels got=%0d/%0d exp=0/0", sel1, sel2); end
        checks++; if (pending !== 32'h0) begin failures++; $display("FAIL x0_pending got=%h exp=0", pending); end
        checks++; if (nf_stall !== 1'b0) begin failures++; $display("FAIL x0_nf_stall got=%0b exp=0", nf_stall); end
    endtask

    task automatic test_flush();
        do_reset();
        set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);   // lw x7
        tick();
        flush = 1'b1;
        set_dec(1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%0b exp=0", stall); end
        tick();
        flush = 1'b0;
        set_dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++; if (pending !== 32'h0000_0080) begin failures++; $display("FAIL flush_pending got=%h exp=00000080", pending); end
        checks++; if (cnt !== 16'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", cnt); end
    endtask

    task automatic test_hold();
        do_reset();
        set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);   // addi x5
        tick();
        set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);   // lw x7
        tick();
        hold = 1'b1;
        set_dec(1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);   // add x8,x7,x0
        for (int c = 0; c < 4; c++) begin
            checks++; if (stall !== 1'b1) begin failures++; $display("FAIL hold_stall cycle=%0d got=%0b exp=1", c, stall); end
            checks++; if (pending !== 32'h0000_00a0) begin failures++; $display("FAIL hold_pending cycle=%0d got=%h exp=000000a0", c, pending); end
            tick();
            checks++; if (cnt !== 16'd0) begin failures++; $display("FAIL hold_count cycle=%0d got=%0d exp=0", c, cnt); end
        end
        // Flush during hold clears only EXEC.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (pending !== 32'h0000_0020) begin failures++; $display("FAIL hold_flush_pending got=%h exp=00000020", pending); end
        hold = 1'b0;
        set_dec(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);
        checks++; if (sel1 !== 2'd2) begin failures++; $display("FAIL hold_sel1 got=%0d exp=2", sel1); end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        #1;
        checks++; if (pending !== 32'h0) begin failures++; $display("FAIL midrst_pending got=%h exp=0", pending); end
        checks++; if (cnt !== 16'd0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", cnt); end
        checks++; if (sel1 !== 2'd0) begin failures++; $display("FAIL midrst_sel1 got=%0d exp=0", sel1); end
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; hold = 1'b0;
        set_dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        test_reset();
        test_forward_alu();
        test_load_use();
        test_stall_only();
        test_x0();
        test_flush();
        test_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
